// File: rtl/bp_fe_lce_cmd_handler.sv
// bp_fe_lce_cmd_handler: applies CCE commands to the I-cache tag/data memories and
//   returns sync/invalidate acks.
//   cmd_*        inbound CCE command (valid/yumi handshake)
//   mem_*        arbitrated tag/data write port (held until mem_gnt_i)
//   *_received_o one-cycle completion strobes for the LCE request FSM
//   lce_resp_*   sync_ack / inv_ack response channel
//   synced_o, error_o, coherence_blocked_o status
module bp_fe_lce_cmd_handler #(
   parameter int paddr_width_p     = 40,
   parameter int lce_assoc_p       = 8,
   parameter int lce_sets_p        = 64,
   parameter int cce_block_width_p = 512,
   parameter int num_cce_p         = 1
) (
   input  logic                                                 clk_i,
   input  logic                                                 reset_n_i,
   input  logic                                                 cmd_v_i,
   output logic                                                 cmd_yumi_o,
   input  logic [2:0]                                           cmd_type_i,
   input  logic [paddr_width_p-1:0]                             cmd_addr_i,
   input  logic [$clog2(lce_assoc_p)-1:0]                       cmd_way_i,
   input  logic [1:0]                                           cmd_state_i,
   input  logic [cce_block_width_p-1:0]                         cmd_data_i,
   output logic                                                 mem_v_o,
   input  logic                                                 mem_gnt_i,
   output logic                                                 mem_tag_w_o,
   output logic [$clog2(lce_sets_p)-1:0]                        mem_index_o,
   output logic [$clog2(lce_assoc_p)-1:0]                       mem_way_o,
   output logic [paddr_width_p-6-$clog2(lce_sets_p)-1:0]        mem_tag_o,
   output logic [1:0]                                           mem_state_o,
   output logic [cce_block_width_p-1:0]                         mem_data_o,
   output logic [63:0]                                          uc_data_o,
   output logic                                                 cce_data_received_o,
   output logic                                                 set_tag_received_o,
   output logic                                                 set_tag_wakeup_received_o,
   output logic                                                 uncached_data_received_o,
   output logic                                                 coherence_blocked_o,
   output logic                                                 lce_resp_v_o,
   output logic                                                 lce_resp_type_o,
   output logic [paddr_width_p-1:0]                             lce_resp_addr_o,
   input  logic                                                 lce_resp_yumi_i,
   output logic                                                 synced_o,
   output logic                                                 error_o
);
   localparam int iw = $clog2(lce_sets_p);
   localparam int ww = $clog2(lce_assoc_p);
   localparam int cw = $clog2(num_cce_p + 1);
   localparam logic [cw-1:0] sync_max = cw'(num_cce_p);
   localparam logic [2:0] c_sync = 3'd0, c_inv = 3'd1, c_st = 3'd2, c_stw = 3'd3, c_data = 3'd4, c_uc = 3'd5;
   typedef enum logic [1:0] {e_ready, e_mem_wait, e_send_resp} state_e;
   state_e                       state;
   logic [2:0]                   type_r;
   logic [paddr_width_p-1:0]     addr_r;
   logic [ww-1:0]                way_r;
   logic [1:0]                   st_r;
   logic [cce_block_width_p-1:0] data_r;
   logic                         uc_r, err_r;
   logic [cw-1:0]                cnt;
   logic                         grant;
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state  <= e_ready;
         type_r <= '0;
         addr_r <= '0;
         way_r  <= '0;
         st_r   <= '0;
         data_r <= '0;
         uc_r   <= 1'b0;
         err_r  <= 1'b0;
         cnt    <= '0;
      end else begin
         uc_r <= 1'b0;
         case (state)
            e_ready:
               if (cmd_v_i) begin
                  type_r <= cmd_type_i;
                  addr_r <= cmd_addr_i;
                  way_r  <= cmd_way_i;
                  st_r   <= cmd_state_i;
                  data_r <= cmd_data_i;
                  uc_r   <= cmd_type_i == c_uc;
                  err_r  <= err_r | (cmd_type_i > c_uc);
                  state  <= cmd_type_i == c_sync ? e_send_resp
                          : cmd_type_i >= c_uc   ? e_ready : e_mem_wait;
               end
            e_mem_wait:
               if (mem_gnt_i) state <= type_r == c_inv ? e_send_resp : e_ready;
            e_send_resp:
               if (lce_resp_yumi_i) begin
                  if (type_r == c_sync && cnt != sync_max) cnt <= cnt + 1'b1;
                  state <= e_ready;
               end
            default: state <= e_ready;
         endcase
      end
   end
   assign cmd_yumi_o                = cmd_v_i & (state == e_ready);
   assign mem_v_o                   = state == e_mem_wait;
   assign grant                     = mem_v_o & mem_gnt_i;
   assign coherence_blocked_o       = mem_v_o & ~mem_gnt_i;
   assign mem_tag_w_o               = mem_v_o & (type_r != c_data);
   assign mem_index_o               = addr_r[6 +: iw];
   assign mem_tag_o                 = addr_r[paddr_width_p-1:6+iw];
   assign mem_way_o                 = way_r;
   assign mem_state_o               = type_r == c_inv ? 2'b00 : st_r;
   assign mem_data_o                = data_r;
   assign uc_data_o                 = data_r[63:0];
   assign cce_data_received_o       = grant & (type_r == c_data);
   assign set_tag_received_o        = grant & (type_r == c_st);
   assign set_tag_wakeup_received_o = grant & (type_r == c_stw);
   assign uncached_data_received_o  = uc_r;
   assign lce_resp_v_o              = state == e_send_resp;
   assign lce_resp_type_o           = type_r == c_inv;
   assign lce_resp_addr_o           = addr_r;
   assign synced_o                  = cnt == sync_max;
   assign error_o                   = err_r;
endmodule

// File: tb/tb_bp_fe_lce_cmd_handler.sv
// tb_bp_fe_lce_cmd_handler: directed bench for bp_fe_lce_cmd_handler (num_cce_p = 2)
module tb_bp_fe_lce_cmd_handler;
   logic          clk_i = 1'b0, reset_n_i = 1'b0;
   logic          cmd_v_i = 1'b0, cmd_yumi_o;
   logic [2:0]    cmd_type_i = '0;
   logic [39:0]   cmd_addr_i = '0;
   logic [2:0]    cmd_way_i = '0;
   logic [1:0]    cmd_state_i = '0;
   logic [511:0]  cmd_data_i = '0;
   logic          mem_v_o, mem_gnt_i = 1'b0, mem_tag_w_o;
   logic [5:0]    mem_index_o;
   logic [2:0]    mem_way_o;
   logic [27:0]   mem_tag_o;
   logic [1:0]    mem_state_o;
   logic [511:0]  mem_data_o;
   logic [63:0]   uc_data_o;
   logic          cce_data_received_o, set_tag_received_o, set_tag_wakeup_received_o;
   logic          uncached_data_received_o, coherence_blocked_o;
   logic          lce_resp_v_o, lce_resp_type_o, lce_resp_yumi_i = 1'b0;
   logic [39:0]   lce_resp_addr_o;
   logic          synced_o, error_o;
   int            n_cmp = 0, n_err = 0;
   logic [511:0]  d1, d2, d3;

   bp_fe_lce_cmd_handler #(.num_cce_p(2)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .cmd_v_i(cmd_v_i), .cmd_yumi_o(cmd_yumi_o),
      .cmd_type_i(cmd_type_i), .cmd_addr_i(cmd_addr_i), .cmd_way_i(cmd_way_i),
      .cmd_state_i(cmd_state_i), .cmd_data_i(cmd_data_i), .mem_v_o(mem_v_o),
      .mem_gnt_i(mem_gnt_i), .mem_tag_w_o(mem_tag_w_o), .mem_index_o(mem_index_o),
      .mem_way_o(mem_way_o), .mem_tag_o(mem_tag_o), .mem_state_o(mem_state_o),
      .mem_data_o(mem_data_o), .uc_data_o(uc_data_o),
      .cce_data_received_o(cce_data_received_o), .set_tag_received_o(set_tag_received_o),
      .set_tag_wakeup_received_o(set_tag_wakeup_received_o),
      .uncached_data_received_o(uncached_data_received_o),
      .coherence_blocked_o(coherence_blocked_o), .lce_resp_v_o(lce_resp_v_o),
      .lce_resp_type_o(lce_resp_type_o), .lce_resp_addr_o(lce_resp_addr_o),
      .lce_resp_yumi_i(lce_resp_yumi_i), .synced_o(synced_o), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge; inputs are then driven and checked #1 later
   task automatic cyc();
      @(posedge clk_i);
      #2;
   endtask

   task automatic cmd(input logic [2:0] t, input logic [39:0] a, input logic [2:0] w,
                      input logic [1:0] s, input logic [511:0] d);
      cmd_v_i = 1'b1; cmd_type_i = t; cmd_addr_i = a; cmd_way_i = w; cmd_state_i = s; cmd_data_i = d;
   endtask

   initial begin
      d1 = {8{64'h0123_4567_89AB_CDEF}};
      d2 = {{7{64'h5555_AAAA_5555_AAAA}}, 64'hDEAD_BEEF_0123_4567};
      d3 = {{7{64'h0}}, 64'h1111_2222_3333_4444};
      cyc(); cyc();
      #1;
      chk("rst_mem_v", mem_v_o, 0);
      chk("rst_resp_v", lce_resp_v_o, 0);
      chk("rst_synced", synced_o, 0);
      chk("rst_error", error_o, 0);
      chk("rst_yumi", cmd_yumi_o, 0);
      reset_n_i = 1'b1;
      cyc();
      // two syncs, response yumi one cycle late
      for (int k = 0; k < 2; k++) begin
         cmd(3'd0, 40'h00_0000_1000 + 40'(k), 3'd0, 2'd0, '0);
         #1;
         chk("sync_yumi", cmd_yumi_o, 1);
         cyc();
         cmd_v_i = 1'b0;
         #1;
         chk("sync_resp_v0", lce_resp_v_o, 1);
         chk("sync_resp_type", lce_resp_type_o, 0);
         chk("sync_resp_addr", lce_resp_addr_o, 40'h00_0000_1000 + 40'(k));
         cyc();
         lce_resp_yumi_i = 1'b1;
         #1;
         chk("sync_resp_v1", lce_resp_v_o, 1);
         chk("sync_synced_pre", synced_o, 0);
         cyc();
         lce_resp_yumi_i = 1'b0;
         #1;
         chk("sync_resp_done", lce_resp_v_o, 0);
         chk("synced_after", synced_o, k == 1);
      end
      // set_tag with immediate grant
      cmd(3'd2, 40'h80_0000_1040, 3'd3, 2'd2, '0);
      mem_gnt_i = 1'b1;
      #1;
      chk("st_yumi", cmd_yumi_o, 1);
      chk("st_mem_v_n", mem_v_o, 0);
      cyc();
      cmd_v_i = 1'b0;
      #1;
      chk("st_mem_v", mem_v_o, 1);
      chk("st_tag_w", mem_tag_w_o, 1);
      chk("st_index", mem_index_o, 6'h01);
      chk("st_tag", mem_tag_o, 28'h800_0001);
      chk("st_way", mem_way_o, 3);
      chk("st_state", mem_state_o, 2);
      chk("st_strobe", set_tag_received_o, 1);
      chk("st_blocked", coherence_blocked_o, 0);
      chk("st_resp_v", lce_resp_v_o, 0);
      cyc();
      #1;
      chk("st_strobe_off", set_tag_received_o, 0);
      chk("st_mem_v_off", mem_v_o, 0);
      // data with grant withheld 5 cycles
      mem_gnt_i = 1'b0;
      cmd(3'd4, 40'h00_0000_2080, 3'd6, 2'd1, d1);
      #1;
      chk("d_yumi", cmd_yumi_o, 1);
      cyc();
      cmd_v_i = 1'b0;
      cmd_data_i = '0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("d_blocked", coherence_blocked_o, 1);
         chk("d_data", mem_data_o, d1);
         chk("d_tag_w", mem_tag_w_o, 0);
         chk("d_way", mem_way_o, 6);
         chk("d_strobe_n", cce_data_received_o, 0);
         cyc();
      end
      mem_gnt_i = 1'b1;
      #1;
      chk("d_blocked_g", coherence_blocked_o, 0);
      chk("d_strobe", cce_data_received_o, 1);
      chk("d_data_g", mem_data_o, d1);
      cyc();
      #1;
      chk("d_strobe_off", cce_data_received_o, 0);
      chk("d_mem_v_off", mem_v_o, 0);
      // invalidate, response yumi delayed 3 cycles
      cmd(3'd1, 40'h12_3456_7880, 3'd5, 2'd3, '0);
      #1;
      chk("inv_yumi", cmd_yumi_o, 1);
      cyc();
      cmd_type_i = 3'd4;
      #1;
      chk("inv_mem_v", mem_v_o, 1);
      chk("inv_tag_w", mem_tag_w_o, 1);
      chk("inv_state", mem_state_o, 0);
      chk("inv_way", mem_way_o, 5);
      chk("inv_no_strobe", set_tag_received_o | set_tag_wakeup_received_o | cce_data_received_o, 0);
      chk("inv_cmd_yumi_w", cmd_yumi_o, 0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         lce_resp_yumi_i = (i == 3);
         #1;
         chk("inv_resp_v", lce_resp_v_o, 1);
         chk("inv_resp_type", lce_resp_type_o, 1);
         chk("inv_resp_addr", lce_resp_addr_o, 40'h12_3456_7880);
         chk("inv_cmd_yumi", cmd_yumi_o, 0);
         cyc();
         cmd_v_i = 1'b0;
      end
      lce_resp_yumi_i = 1'b0;
      #1;
      chk("inv_resp_off", lce_resp_v_o, 0);
      chk("inv_synced", synced_o, 1);
      cyc();
      // uc_data back to back
      cmd(3'd5, 40'h00_0000_3000, 3'd0, 2'd0, d2);
      #1;
      chk("uc_yumi", cmd_yumi_o, 1);
      chk("uc_mem_v0", mem_v_o, 0);
      cyc();
      cmd(3'd5, 40'h00_0000_3040, 3'd0, 2'd0, d3);
      #1;
      chk("uc_strobe", uncached_data_received_o, 1);
      chk("uc_data", uc_data_o, 64'hDEAD_BEEF_0123_4567);
      chk("uc_mem_v1", mem_v_o, 0);
      chk("uc_next_yumi", cmd_yumi_o, 1);
      cyc();
      cmd_v_i = 1'b0;
      #1;
      chk("uc_strobe2", uncached_data_received_o, 1);
      chk("uc_data2", uc_data_o, 64'h1111_2222_3333_4444);
      chk("uc_mem_v2", mem_v_o, 0);
      cyc();
      #1;
      chk("uc_strobe_off", uncached_data_received_o, 0);
      // reserved type
      cmd(3'd7, 40'h0, 3'd0, 2'd0, '0);
      #1;
      chk("rsv_yumi", cmd_yumi_o, 1);
      chk("rsv_err_pre", error_o, 0);
      cyc();
      cmd_v_i = 1'b0;
      #1;
      chk("rsv_err", error_o, 1);
      chk("rsv_mem_v", mem_v_o, 0);
      chk("rsv_resp_v", lce_resp_v_o, 0);
      // set_tag_wakeup with grant
      cmd(3'd3, 40'h00_0000_0FC0, 3'd7, 2'd1, '0);
      #1;
      cyc();
      cmd_v_i = 1'b0;
      #1;
      chk("stw_strobe", set_tag_wakeup_received_o, 1);
      chk("stw_st_strobe", set_tag_received_o, 0);
      chk("stw_index", mem_index_o, 6'h3F);
      chk("stw_state", mem_state_o, 1);
      cyc();
      // data stalled, then async reset mid e_mem_wait
      mem_gnt_i = 1'b0;
      cmd(3'd4, 40'hFF_FFFF_FFC0, 3'd2, 2'd3, d1);
      #1;
      cyc();
      cmd_v_i = 1'b0;
      #1;
      chk("rst2_pre_v", mem_v_o, 1);
      chk("rst2_pre_err", error_o, 1);
      cyc();
      reset_n_i = 1'b0;
      #1;
      chk("rst2_mem_v", mem_v_o, 0);
      chk("rst2_blocked", coherence_blocked_o, 0);
      chk("rst2_err", error_o, 0);
      chk("rst2_synced", synced_o, 0);
      chk("rst2_tag", mem_tag_o, 0);
      chk("rst2_data", mem_data_o, 0);
      chk("rst2_strobe", cce_data_received_o, 0);
      chk("rst2_resp_v", lce_resp_v_o, 0);
      mem_gnt_i = 1'b1;
      cyc();
      #1;
      chk("rst2_hold_strobe", cce_data_received_o, 0);
      reset_n_i = 1'b1;
      cyc();
      #1;
      chk("rst2_after", mem_v_o, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/bp_fe_lce_cmd_handler.md
# bp_fe_lce_cmd_handler

Inbound coherence-command stage of the front-end I-cache LCE. It accepts CCE commands (sync, invalidate, set-tag, set-tag-wakeup, data, uncached data) and applies them to the I-cache tag and data memories through an arbitrated write port. For each command it pulses the matching completion strobe consumed by the LCE request FSM, and it returns sync and invalidate acknowledgements on the LCE response channel. It drives `coherence_blocked_o`, which feeds the request block's timeout counter.

## Interface
- paddr_width_p, 40, physical address width
- lce_assoc_p, 8, ways per set
- lce_sets_p, 64, sets; index_width = clog2(lce_sets_p)
- cce_block_width_p, 512, cache block width in bits
- num_cce_p, 1, sync commands required before `synced_o` rises
- clk_i  input  1  clock, rising edge
- reset_n_i  input  1  reset, asynchronous, active-low
- cmd_v_i  input  1  command valid
- cmd_yumi_o  output  1  command consumed this cycle
- cmd_type_i  input  3  0 sync, 1 invalidate, 2 set_tag, 3 set_tag_wakeup, 4 data, 5 uc_data, 6-7 reserved
- cmd_addr_i  input  paddr_width_p  target address
- cmd_way_i  input  clog2(lce_assoc_p)  target way
- cmd_state_i  input  2  coherence state written by set_tag and set_tag_wakeup
- cmd_data_i  input  cce_block_width_p  block data for data and uc_data
- mem_v_o  output  1  memory write request
- mem_gnt_i  input  1  cache grants the write slot this cycle
- mem_tag_w_o  output  1  1 = tag write, 0 = data write
- mem_index_o  output  index_width  set index, taken from addr above the 6-bit block offset
- mem_way_o  output  clog2(lce_assoc_p)  way
- mem_tag_o  output  paddr_width_p-6-index_width  tag
- mem_state_o  output  2  state; 0 for invalidate
- mem_data_o  output  cce_block_width_p  block data
- uc_data_o  output  64  low 64 bits of the uc_data block; valid during the uc strobe
- cce_data_received_o  output  1  one-cycle strobe
- set_tag_received_o  output  1  one-cycle strobe
- set_tag_wakeup_received_o  output  1  one-cycle strobe
- uncached_data_received_o  output  1  one-cycle strobe
- coherence_blocked_o  output  1  memory write pending and not granted
- lce_resp_v_o  output  1  response valid
- lce_resp_type_o  output  1  0 sync_ack, 1 inv_ack
- lce_resp_addr_o  output  paddr_width_p  echoed command address
- lce_resp_yumi_i  input  1  response consumed
- synced_o  output  1  num_cce_p sync commands acknowledged
- error_o  output  1  sticky; set when a reserved command type is received

## Operation
- FSM states:
  - e_ready: `cmd_yumi_o = cmd_v_i` (combinational). On yumi, latch type, addr, way, state and data. Next state:
    - sync → e_send_resp
    - uc_data → e_ready; fire `uncached_data_received_o` the next cycle from a registered strobe
    - reserved → e_ready; set `error_o`
    - all other types → e_mem_wait
  - e_mem_wait: `mem_v_o = 1`.
    - `mem_tag_w_o = 1` for invalidate, set_tag and set_tag_wakeup; 0 for data.
    - On `mem_gnt_i`: the write occurs that cycle and the matching strobe pulses that same cycle (none for invalidate). Next state is e_send_resp for invalidate, else e_ready.
  - e_send_resp: hold `lce_resp_v_o` and its fields stable until `lce_resp_yumi_i`. Type is 0 for sync, 1 for invalidate. On yumi go to e_ready.
    - If the command was a sync, increment the sync counter, saturating at num_cce_p.
    - `synced_o = (count == num_cce_p)`.
- `cmd_yumi_o` is 0 outside e_ready.
- Each command produces at most one strobe. Strobes never overlap.
- `coherence_blocked_o = mem_v_o & ~mem_gnt_i`.
- The state field of a set_tag or set_tag_wakeup is written unmodified. The data write uses the full block.

## Timing
- Reset: all outputs 0, FSM in e_ready, sync counter 0, `error_o` 0. An async assert mid-operation abandons the latched command without a strobe or response. Deassertion is synchronised by the integrator.
- Command accepted at cycle N: `mem_v_o` rises at N+1. With immediate grant, the strobe is at N+1 and e_ready is re-entered at N+2. Sustained throughput is one memory command per 2 cycles.
- uc_data: strobe at N+1, next accept at N+1.
- Sync/invalidate response: `lce_resp_v_o` rises the cycle after the grant (invalidate) or at N+1 (sync). `lce_resp_v_o` is held under backpressure with fields unchanged.
- Withheld grant: `mem_v_o` and all mem fields are held. `coherence_blocked_o` stays high every ungranted cycle.
- No new command is consumed while a write or response is pending.

## Test plan
- Reset, then 2 syncs with num_cce_p=2 and yumi 1 cycle late → two resps, type 0; `synced_o` rises the cycle after the second yumi.
- set_tag addr 0x80_0000_1040, way 3, state 2, grant immediate → `mem_index_o` 0x01, `mem_tag_o` 0x80_0000_1040>>12, `set_tag_received_o` one pulse at N+1, no resp.
- data cmd with grant withheld 5 cycles → `coherence_blocked_o` high 5 cycles, `mem_data_o` stable, `cce_data_received_o` on the grant cycle only.
- invalidate with resp yumi delayed 3 cycles → tag write state 0; `lce_resp_v_o` held 4 cycles, type 1, addr echoed; `cmd_yumi_o` stays 0 throughout.
- uc_data with low word 0xDEAD_BEEF_0123_4567 → `uc_data_o` matches, `uncached_data_received_o` at N+1, `mem_v_o` never asserts.
- Reserved type 7 → consumed, `error_o` latches 1; assert reset_n_i mid e_mem_wait → all outputs 0 immediately.
